ps2_key_event_decoder: RTL and testbench

Clocked, parametrised PS/2 scan-code decoder that turns the received byte stream into per-key held levels and one-cycle press/release pulses for a configurable table of keys. It sits between the PS/2 byte receiver and the game/benchmark control FSMs. It handles break (F0) and extended (E0) prefixes, filters typematic repeats, ignores keyboard protocol bytes, and abandons stale prefixes after a timeout.

---
 rtl/ps2_keydec_pkg.sv | 26 ++
 rtl/ps2_key_match.sv | 27 ++
 rtl/ps2_key_event_decoder.sv | 149 ++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_keydec_pkg.sv
// Shared types and byte constants for the PS/2 key event decoder.
package ps2_keydec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } state_t;

    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_FF = 8'hFF;

    // Keyboard-to-host protocol bytes that never carry key information.
    function automatic logic is_protocol_byte(input logic [7:0] b);
        return (b == BYTE_00) || (b == BYTE_AA) || (b == BYTE_EE) ||
               (b == BYTE_FA) || (b == BYTE_FE) || (b == BYTE_FF);
    endfunction

endpackage

// File: rtl/ps2_key_match.sv
// Combinational lookup of {ext, code} against the key table.
// PS2_KEYDEC_EXT_EN selects full 9-bit compares; otherwise bit 8 of each entry is ignored.
module ps2_key_match #(
    parameter int unsigned            NUM_KEYS  = 4,
    parameter logic [NUM_KEYS*9-1:0]  KEY_CODES = {9'h01E, 9'h016, 9'h05A, 9'h029}
) (
    input  logic                ext,
    input  logic [7:0]          code,
    output logic [NUM_KEYS-1:0] match,
    output logic                no_match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
`ifdef PS2_KEYDEC_EXT_EN
            match[i] = (KEY_CODES[9*i +: 9] == {ext, code});
`else
            // ext can never be set without E0 handling, so it only masks here
            match[i] = (KEY_CODES[9*i +: 8] == code) & ~ext;
`endif
        end
    end

    assign no_match = ~|match;

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code decoder: per-key held levels plus one-cycle press/release pulses.
// Define PS2_KEYDEC_EXT_EN to enable E0 (extended) prefix handling.
module ps2_key_event_decoder
    import ps2_keydec_pkg::*;
#(
    parameter int unsigned            NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*9-1:0]  KEY_CODES      = {9'h01E, 9'h016, 9'h05A, 9'h029},
    parameter int unsigned            TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [7:0]          byte_data,
    input  logic                byte_valid,
    input  logic                clear,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_held,
    output logic                unknown_code
);

    state_t state_q, state_d;

    logic                is_e0, is_f0, is_proto;
    logic                byte_act, code_act;
    logic                ext_mode, brk_mode;
    logic                timeout_hit;
    logic [NUM_KEYS-1:0] match;
    logic                no_match;

    logic [NUM_KEYS-1:0] held_d, press_d, release_d;
    logic                unknown_d;

    assign is_e0    = (byte_data == BYTE_E0);
    assign is_f0    = (byte_data == BYTE_F0);
    assign is_proto = is_protocol_byte(byte_data);

`ifdef PS2_KEYDEC_EXT_EN
    assign byte_act = byte_valid & ~clear;
`else
    // Without extended support an E0 byte is treated as if nothing arrived.
    assign byte_act = byte_valid & ~clear & ~is_e0;
`endif
    assign code_act = byte_act & ~is_e0 & ~is_f0 & ~is_proto;

    assign ext_mode = (state_q == ST_EXT)   || (state_q == ST_EXT_BREAK);
    assign brk_mode = (state_q == ST_BREAK) || (state_q == ST_EXT_BREAK);

    ps2_key_match #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_CODES (KEY_CODES)
    ) u_match (
        .ext      (ext_mode),
        .code     (byte_data),
        .match    (match),
        .no_match (no_match)
    );

    // Stale-prefix timer: cleared by any accepted byte, runs only while a prefix is pending.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
            logic [TW-1:0] timer_q, timer_d;
            logic          hit;

            always_comb begin
                timer_d = timer_q;
                hit     = 1'b0;
                if (clear || byte_act) begin
                    timer_d = '0;
                end else if (state_q != ST_IDLE) begin
                    if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        hit     = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (!resetn) timer_q <= '0;
                else         timer_q <= timer_d;
            end

            assign timeout_hit = hit;
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (byte_act) begin
            if (is_e0)      state_d = ST_EXT;
            else if (is_f0) state_d = ext_mode ? ST_EXT_BREAK : ST_BREAK;
            else            state_d = ST_IDLE;
        end else if (timeout_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Output logic: next values of the held register and pulses
    always_comb begin
        held_d    = key_held;
        press_d   = '0;
        release_d = '0;
        unknown_d = 1'b0;
        if (clear) begin
            held_d = '0;
        end else if (code_act) begin
            if (no_match) begin
                unknown_d = 1'b1;
            end else if (brk_mode) begin
                release_d = match & key_held;
                held_d    = key_held & ~match;
            end else begin
                press_d = match & ~key_held;
                held_d  = key_held | match;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            key_held     <= '0;
            key_press    <= '0;
            key_release  <= '0;
            unknown_code <= 1'b0;
        end else begin
            key_held     <= held_d;
            key_press    <= press_d;
            key_release  <= release_d;
            unknown_code <= unknown_d;
        end
    end

    assign any_held = |key_held;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench for ps2_key_event_decoder: directed scenarios then random byte traffic.
module tb_ps2_key_event_decoder;

    localparam int unsigned NK = 4;
    localparam int unsigned TO = 16;
    localparam logic [NK*9-1:0] KC = {9'h01E, 9'h016, 9'h05A, 9'h029};
`ifdef PS2_KEYDEC_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_valid = 1'b0;
    logic          clear = 1'b0;
    logic [NK-1:0] key_held, key_press, key_release;
    logic          any_held, unknown_code;

    ps2_key_event_decoder #(
        .NUM_KEYS       (NK),
        .KEY_CODES      (KC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .clear        (clear),
        .key_held     (key_held),
        .key_press    (key_press),
        .key_release  (key_release),
        .any_held     (any_held),
        .unknown_code (unknown_code)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NK-1:0] held;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic          unk;
        logic          any;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: table of keys, set of held keys, pending prefix flags, idle time.
    logic [8:0]    tbl [NK] = '{9'h029, 9'h05A, 9'h016, 9'h01E};
    logic [NK-1:0] m_held = '0;
    bit            m_brk = 1'b0;
    bit            m_ext = 1'b0;
    int            m_idle = 0;

    task automatic model_step(input logic rn, input logic cl, input logic bv, input logic [7:0] b);
        obs_t e;
        bit   hit;
        logic [8:0] ent;
        e = '0;
        if (!rn || cl) begin
            m_held = '0; m_brk = 0; m_ext = 0; m_idle = 0;
        end else if (bv && !(b == 8'hE0 && !EXT)) begin
            m_idle = 0;
            if (b == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
                m_brk = 0; m_ext = 0;
            end else begin
                hit = 0;
                for (int i = 0; i < int'(NK); i++) begin
                    ent = tbl[i];
                    if (EXT ? (ent == {m_ext, b}) : (ent[7:0] == b)) begin
                        hit = 1;
                        if (m_brk && m_held[i]) begin
                            m_held[i] = 1'b0; e.rel[i] = 1'b1;
                        end else if (!m_brk && !m_held[i]) begin
                            m_held[i] = 1'b1; e.press[i] = 1'b1;
                        end
                    end
                end
                e.unk = !hit;
                m_brk = 0; m_ext = 0;
            end
        end else if (m_brk || m_ext) begin
            m_idle++;
            if (m_idle == int'(TO)) begin
                m_brk = 0; m_ext = 0; m_idle = 0;
            end
        end
        e.held = m_held;
        e.any  = |m_held;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; expectation for the following edge goes to the scoreboard.
    task automatic drive(input logic rn, input logic cl, input logic bv, input logic [7:0] b);
        @(negedge clock);
        resetn = rn; clear = cl; byte_valid = bv; byte_data = b;
        model_step(rn, cl, bv, b);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, 1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compare registered outputs just after every edge that has a pending expectation.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {key_held, key_press, key_release, unknown_code, any_held};
                checks++;
                if (a === e) passed++;
                else $display("FAIL outputs t=%0t held/press/rel/unk/any got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                              $time, a.held, a.press, a.rel, a.unk, a.any,
                              e.held, e.press, e.rel, e.unk, e.any);
            end
        end
    end

    logic [7:0] pool [14] = '{8'h29, 8'h5A, 8'h16, 8'h1E, 8'hF0, 8'hF0, 8'hE0,
                             8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'h75};

    initial begin
        logic [7:0] b;
        int idx;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clock);
        #2;
        checks++;
        if (key_held === '0 && key_press === '0 && key_release === '0 &&
            unknown_code === 1'b0 && any_held === 1'b0) passed++;
        else $display("FAIL reset state t=%0t held/press/rel/unk/any %b/%b/%b/%b/%b",
                      $time, key_held, key_press, key_release, unknown_code, any_held);

        send(8'h29); idle(2); send(8'hF0); send(8'h29); idle(2);
        send(8'h5A); idle(1); send(8'h5A); send(8'h5A); idle(2);
        send(8'hF0); send(8'h5A); idle(1);

        send(8'hF0); idle(TO); send(8'h16);
        @(posedge clock);
        #2;
        checks++;
        if (key_press === NK'(4) && key_release === '0 && key_held[2] === 1'b1) passed++;
        else $display("FAIL expired wait t=%0t press/rel/held %b/%b/%b",
                      $time, key_press, key_release, key_held);
        idle(2);
        send(8'hF0); idle(TO - 1); send(8'h16); idle(2);
        send(8'hF0); idle(TO + 3); send(8'h16); idle(1);

        send(8'h29); send(8'h1E); drive(1'b1, 1'b1, 1'b1, 8'h16); idle(2);
        send(8'hAA); send(8'hFA); send(8'h44); idle(1);

        send(8'h29); send(8'hE0); send(8'hF0);
        drive(1'b0, 1'b0, 1'b1, 8'h29); drive(1'b0, 1'b1, 1'b0, 8'h00);
        send(8'h1E); idle(1);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h1E); idle(TO + 2);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 40) == 0) begin
                idle(int'($urandom_range(TO - 2, TO + 2)));
            end else begin
                idx = int'($urandom_range(0, 13));
                b = (idx == 13) ? 8'($urandom) : pool[idx];
                drive(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 99) == 0),
                      1'($urandom_range(0, 2) != 0), b);
            end
        end
        idle(3);
        @(posedge clock);
        #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
